tx_scheduler: RTL and testbench
===============================

# tx_scheduler

Transmit scheduler that owns the `word_to_byte_tx` serializer and shares it between two requesters: the error-reporting path (single status byte) and the memory read-data path (32-bit word). Requests are queued in a small FIFO with fixed priority on entry. The drain FSM issues exactly one serializer job at a time, waits for `o_done`, enforces an inter-frame gap and recovers from a hung serializer via a timeout. It sits between the command-interpreter FSM in `top` and `word_to_byte_tx`, so the interpreter never has to track serializer busy state.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `GAP_CYCLES`, 16: idle clocks enforced after each job completes; 0 disables the gap.
- `TIMEOUT_CYCLES`, 1_000_000: maximum clocks to wait for `i_wtb_done` before abandoning a job.

- `clock`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_err_valid`  in  1  error byte request.
- `i_err_byte`  in  8  error code.
- `o_err_ready`  out  1  error request accepted this edge when high with valid.
- `i_data_valid`  in  1  read-data word request.
- `i_data_word`  in  32  word to send.
- `o_data_ready`  out  1  data request accepted this edge when high with valid.
- `o_wtb_enable`  out  1  one-cycle start pulse to serializer.
- `o_wtb_mode_select`  out  1  1 = word mode, 0 = byte mode.
- `o_wtb_word`  out  32  word payload (word mode).
- `o_wtb_byte`  out  8  byte payload (byte mode).
- `i_wtb_done`  in  1  one-cycle pulse from serializer at job end.
- `o_level`  out  clog2(DEPTH)+1  current FIFO occupancy.
- `o_busy`  out  1  high whenever the FSM is not in IDLE or `o_level` ≠ 0.
- `o_timeout`  out  1  one-cycle pulse when a job is abandoned.

## Operation
- FIFO entry is 41 bits: {mode, byte[7:0], word[31:0]}. Error push stores mode=0 with the byte; data push stores mode=1 with the word.
- Entry arbitration: at most one push per cycle. `o_err_ready` = !full. `o_data_ready` = !full && !i_err_valid, so error wins when both are valid. Full is the registered state; a push at full is refused even if a pop occurs in the same cycle.
- `o_level`: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. Read and write pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if `o_level` ≠ 0, pop the head into the output registers and go to START.
  - START: `o_wtb_enable`=1 for this cycle only; go to WAIT. Clear the timeout counter.
  - WAIT: on `i_wtb_done` go to GAP. If the counter reaches TIMEOUT_CYCLES-1 first, pulse `o_timeout` and go to GAP. `i_wtb_done` is ignored in every state except WAIT.
  - GAP: count GAP_CYCLES clocks, then go to IDLE. With GAP_CYCLES=0, WAIT goes directly to IDLE.
- `o_wtb_mode_select`, `o_wtb_word` and `o_wtb_byte` are registered, load on pop, and stay stable through START, WAIT and GAP.
- Reset: FIFO flushed, pointers and `o_level` cleared, FSM to IDLE. All outputs 0 except `o_wtb_mode_select`=1 and `o_err_ready`=1. `o_data_ready` follows its rule above. A job in flight is abandoned with no done or timeout reported.

## Timing
- A push accepted at edge k is visible at `o_level` after edge k.
- If the FSM is in IDLE, the pop occurs at edge k+1 and `o_wtb_enable` is high during the cycle after edge k+1.
- Back-to-back jobs: the next enable comes GAP_CYCLES+2 clocks after the cycle in which `i_wtb_done` was seen.
- Ready outputs are combinational from the full flag and `i_err_valid`. No other combinational input-to-output paths.
- Timeout counter width is clog2(TIMEOUT_CYCLES). The gap counter saturates and does not wrap.

## Test plan
- Single error push, byte 0x02, idle scheduler → `o_wtb_enable` pulses once with mode=0, byte=0x02, 2 cycles after acceptance; `o_level` returns to 0.
- Simultaneous err (0x01) and data (0xDEADBEEF) valid → error accepted first and data stalled one cycle. Serializer sees the byte job, then after done plus 16 gap cycles the word job with mode=1.
- Fill to DEPTH=4 while the serializer is stalled → both readies low at level 4. A fifth push is refused in the same cycle as a pop and accepted the next cycle; `o_level` never exceeds 4.
- `i_wtb_done` never asserted, TIMEOUT_CYCLES=100 → `o_timeout` pulses exactly 100 cycles after START. The next queued job starts after the gap; a stray done during GAP is ignored.
- Reset asserted in WAIT with 3 entries queued → the next cycle shows level 0, enable 0, mode_select 1 and FSM in IDLE. No job is issued afterwards until a new push.

Source files
------------

// File: rtl/tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tx_scheduler
// Purpose  : Shares one word_to_byte_tx serializer between an error-byte
//            requester and a read-data-word requester. Requests are queued in
//            a small FIFO (error wins on entry); a drain FSM issues one job at
//            a time, waits for done, enforces an inter-frame gap and abandons
//            a job whose done never arrives.
// Revision : 1.0 - initial release
// ============================================================================
module tx_scheduler #(
  parameter int DEPTH          = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_err_valid,
  input  logic [7:0]                 i_err_byte,
  output logic                       o_err_ready,
  input  logic                       i_data_valid,
  input  logic [31:0]                i_data_word,
  output logic                       o_data_ready,
  output logic                       o_wtb_enable,
  output logic                       o_wtb_mode_select,
  output logic [31:0]                o_wtb_word,
  output logic [7:0]                 o_wtb_byte,
  input  logic                       i_wtb_done,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_busy,
  output logic                       o_timeout
);

  localparam int PW         = $clog2(DEPTH);
  localparam int LW         = PW + 1;
  localparam int EW         = 41;
  localparam int TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW         = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LAST_I);
  localparam logic [GW-1:0] GAP_MAX  = '1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            mode_q, mode_d;
  logic [7:0]      byte_q, byte_d;
  logic [31:0]     word_q, word_d;

  logic            full;
  logic            push_err;
  logic            push_data;
  logic            push;
  logic            pop;
  logic [EW-1:0]   push_entry;
  logic [EW-1:0]   head_entry;

  // Entry arbitration and FIFO bookkeeping; full is taken from the registered level only
  always_comb begin
    full       = (level_q == LVL_FULL);
    push_err   = i_err_valid && !full;
    push_data  = i_data_valid && !full && !i_err_valid;
    push       = push_err || push_data;
    push_entry = push_err ? {1'b0, i_err_byte, 32'd0} : {1'b1, 8'd0, i_data_word};
    pop        = (state_q == S_IDLE) && (level_q != '0);
    head_entry = mem_q[rd_ptr_q];

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
    end
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    mode_d = mode_q;
    byte_d = byte_q;
    word_d = word_q;
    if (pop) begin
      mode_d = head_entry[40];
      byte_d = head_entry[39:32];
      word_d = head_entry[31:0];
    end
  end

  // Drain FSM: one serializer job at a time, timeout takes effect on the terminal count
  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_START;
        end
      end
      S_START: begin
        state_d  = S_WAIT;
        to_cnt_d = '0;
      end
      S_WAIT: begin
        if ((to_cnt_q == TO_LAST) || i_wtb_done) begin
          state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          gap_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q != GAP_MAX) begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, FIFO and payload registers; reset flushes everything and drops any job in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      mode_q    <= 1'b1;
      byte_q    <= '0;
      word_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      mode_q    <= mode_d;
      byte_q    <= byte_d;
      word_q    <= word_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Output decode: only the ready pair looks at inputs, everything else is register-derived
  always_comb begin
    o_err_ready       = !full;
    o_data_ready      = !full && !i_err_valid;
    o_wtb_enable      = (state_q == S_START);
    o_wtb_mode_select = mode_q;
    o_wtb_word        = word_q;
    o_wtb_byte        = byte_q;
    o_level           = level_q;
    o_busy            = (state_q != S_IDLE) || (level_q != '0);
    o_timeout         = (state_q == S_WAIT) && (to_cnt_q == TO_LAST);
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_scheduler
// Purpose  : Directed, table-driven bench for tx_scheduler (DEPTH=4,
//            GAP_CYCLES=16, TIMEOUT_CYCLES=100) with hand-written sequences
//            for gap timing, full FIFO, timeout and mid-job reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_err_valid;
  logic [7:0]  i_err_byte;
  logic        o_err_ready;
  logic        i_data_valid;
  logic [31:0] i_data_word;
  logic        o_data_ready;
  logic        o_wtb_enable;
  logic        o_wtb_mode_select;
  logic [31:0] o_wtb_word;
  logic [7:0]  o_wtb_byte;
  logic        i_wtb_done;
  logic [2:0]  o_level;
  logic        o_busy;
  logic        o_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  tx_scheduler #(
    .DEPTH(4),
    .GAP_CYCLES(16),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clock(clock),
    .reset(reset),
    .i_err_valid(i_err_valid),
    .i_err_byte(i_err_byte),
    .o_err_ready(o_err_ready),
    .i_data_valid(i_data_valid),
    .i_data_word(i_data_word),
    .o_data_ready(o_data_ready),
    .o_wtb_enable(o_wtb_enable),
    .o_wtb_mode_select(o_wtb_mode_select),
    .o_wtb_word(o_wtb_word),
    .o_wtb_byte(o_wtb_byte),
    .i_wtb_done(i_wtb_done),
    .o_level(o_level),
    .o_busy(o_busy),
    .o_timeout(o_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ev;
    logic [7:0]  eb;
    logic        dv;
    logic [31:0] dw;
    logic        done;
    logic        xer;
    logic        xdr;
    logic [2:0]  xlvl;
    logic        xen;
    logic        xmode;
    logic [7:0]  xbyte;
    logic [31:0] xword;
    logic        xbusy;
    logic        xto;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(logic ev, logic [7:0] eb, logic dv, logic [31:0] dw, logic done,
                              logic xer, logic xdr, logic [2:0] xlvl, logic xen, logic xmode,
                              logic [7:0] xbyte, logic [31:0] xword, logic xbusy, logic xto);
    vec_t v;
    v.ev = ev; v.eb = eb; v.dv = dv; v.dw = dw; v.done = done;
    v.xer = xer; v.xdr = xdr; v.xlvl = xlvl; v.xen = xen; v.xmode = xmode;
    v.xbyte = xbyte; v.xword = xword; v.xbusy = xbusy; v.xto = xto;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic ev, input logic [7:0] eb, input logic dv,
                        input logic [31:0] dw, input logic dn);
    i_err_valid  = ev;
    i_err_byte   = eb;
    i_data_valid = dv;
    i_data_word  = dw;
    i_wtb_done   = dn;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_level"}, 64'(o_level), 64'd0);
    chk({tag, "_enable"}, 64'(o_wtb_enable), 64'd0);
    chk({tag, "_mode"}, 64'(o_wtb_mode_select), 64'd1);
    chk({tag, "_byte"}, 64'(o_wtb_byte), 64'd0);
    chk({tag, "_word"}, 64'(o_wtb_word), 64'd0);
    chk({tag, "_err_ready"}, 64'(o_err_ready), 64'd1);
    chk({tag, "_data_ready"}, 64'(o_data_ready), 64'd1);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_timeout"}, 64'(o_timeout), 64'd0);
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      set_in(vecs[r].ev, vecs[r].eb, vecs[r].dv, vecs[r].dw, vecs[r].done);
      #1;
      chk($sformatf("row%0d_err_ready", r), 64'(o_err_ready), 64'(vecs[r].xer));
      chk($sformatf("row%0d_data_ready", r), 64'(o_data_ready), 64'(vecs[r].xdr));
      chk($sformatf("row%0d_level", r), 64'(o_level), 64'(vecs[r].xlvl));
      chk($sformatf("row%0d_enable", r), 64'(o_wtb_enable), 64'(vecs[r].xen));
      chk($sformatf("row%0d_mode", r), 64'(o_wtb_mode_select), 64'(vecs[r].xmode));
      if (vecs[r].xmode) chk($sformatf("row%0d_word", r), 64'(o_wtb_word), 64'(vecs[r].xword));
      else               chk($sformatf("row%0d_byte", r), 64'(o_wtb_byte), 64'(vecs[r].xbyte));
      chk($sformatf("row%0d_busy", r), 64'(o_busy), 64'(vecs[r].xbusy));
      chk($sformatf("row%0d_timeout", r), 64'(o_timeout), 64'(vecs[r].xto));
      step();
    end
  endtask

  initial begin
    //                 ev eb     dv dw            dn  er dr lvl en md byte   word          bsy to
    // single error byte from idle: enable two cycles after acceptance
    vecs[0] = mk(1, 8'h02, 0, 32'h0,        0,  1, 0, 3'd0, 0, 1, 8'h00, 32'h0,        0, 0);
    vecs[1] = mk(0, 8'h00, 0, 32'h0,        0,  1, 1, 3'd1, 0, 1, 8'h00, 32'h0,        1, 0);
    vecs[2] = mk(0, 8'h00, 0, 32'h0,        0,  1, 1, 3'd0, 1, 0, 8'h02, 32'h0,        1, 0);
    vecs[3] = mk(0, 8'h00, 0, 32'h0,        1,  1, 1, 3'd0, 0, 0, 8'h02, 32'h0,        1, 0);
    vecs[4] = mk(0, 8'h00, 0, 32'h0,        0,  1, 1, 3'd0, 0, 0, 8'h02, 32'h0,        1, 0);
    // error and data together: error first, data stalled one cycle
    vecs[5] = mk(1, 8'h01, 1, 32'hDEADBEEF, 0,  1, 0, 3'd0, 0, 0, 8'h02, 32'h0,        0, 0);
    vecs[6] = mk(0, 8'h00, 1, 32'hDEADBEEF, 0,  1, 1, 3'd1, 0, 0, 8'h02, 32'h0,        1, 0);
    vecs[7] = mk(0, 8'h00, 0, 32'h0,        0,  1, 1, 3'd1, 1, 0, 8'h01, 32'h0,        1, 0);
    vecs[8] = mk(0, 8'h00, 0, 32'h0,        1,  1, 1, 3'd1, 0, 0, 8'h01, 32'h0,        1, 0);

    set_in(0, 8'h00, 0, 32'h0, 0);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk_reset_state("init");

    apply_rows(0, 4);
    for (int j = 0; j < 15; j++) begin
      set_in(0, 8'h00, 0, 32'h0, 0);
      #1;
      chk("gap1_busy", 64'(o_busy), 64'd1);
      chk("gap1_enable", 64'(o_wtb_enable), 64'd0);
      step();
    end

    apply_rows(5, 8);
    // 16 gap clocks plus one idle clock before the word job starts
    for (int j = 0; j < 17; j++) begin
      set_in(0, 8'h00, 0, 32'h0, 0);
      #1;
      chk("gap2_enable", 64'(o_wtb_enable), 64'd0);
      chk("gap2_level", 64'(o_level), 64'd1);
      step();
    end
    #1;
    chk("word_job_enable", 64'(o_wtb_enable), 64'd1);
    chk("word_job_mode", 64'(o_wtb_mode_select), 64'd1);
    chk("word_job_word", 64'(o_wtb_word), 64'hDEADBEEF);
    chk("word_job_level", 64'(o_level), 64'd0);
    step();

    // fill the FIFO while the serializer holds the word job
    for (int k = 1; k <= 4; k++) begin
      set_in(0, 8'h00, 1, 32'(k), 0);
      #1;
      chk("fill_data_ready", 64'(o_data_ready), 64'd1);
      chk("fill_level", 64'(o_level), 64'(k - 1));
      step();
    end
    set_in(1, 8'hEE, 1, 32'd5, 1);
    #1;
    chk("full_level", 64'(o_level), 64'd4);
    chk("full_err_ready", 64'(o_err_ready), 64'd0);
    chk("full_data_ready", 64'(o_data_ready), 64'd0);
    step();
    for (int j = 0; j < 17; j++) begin
      set_in(0, 8'h00, 1, 32'd5, 0);
      #1;
      chk("full_hold_data_ready", 64'(o_data_ready), 64'd0);
      chk("full_hold_level", 64'(o_level), 64'd4);
      chk("full_hold_enable", 64'(o_wtb_enable), 64'd0);
      step();
    end
    #1;
    chk("refill_level", 64'(o_level), 64'd3);
    chk("refill_data_ready", 64'(o_data_ready), 64'd1);
    chk("job1_enable", 64'(o_wtb_enable), 64'd1);
    chk("job1_mode", 64'(o_wtb_mode_select), 64'd1);
    chk("job1_word", 64'(o_wtb_word), 64'd1);
    step();

    // no done: timeout exactly 100 cycles after START
    for (int j = 1; j <= 100; j++) begin
      set_in(0, 8'h00, 0, 32'h0, 0);
      #1;
      chk($sformatf("to_wait%0d_timeout", j), 64'(o_timeout), 64'(j == 100));
      chk("to_wait_level", 64'(o_level), 64'd4);
      step();
    end
    set_in(0, 8'h00, 0, 32'h0, 1);
    #1;
    chk("stray_done_enable", 64'(o_wtb_enable), 64'd0);
    chk("stray_done_timeout", 64'(o_timeout), 64'd0);
    step();
    for (int j = 0; j < 16; j++) begin
      set_in(0, 8'h00, 0, 32'h0, 0);
      #1;
      chk("post_to_gap_enable", 64'(o_wtb_enable), 64'd0);
      step();
    end
    #1;
    chk("job2_enable", 64'(o_wtb_enable), 64'd1);
    chk("job2_word", 64'(o_wtb_word), 64'd2);
    chk("job2_level", 64'(o_level), 64'd3);
    step();

    // reset in WAIT with three entries queued
    #1;
    chk("pre_rst_level", 64'(o_level), 64'd3);
    chk("pre_rst_busy", 64'(o_busy), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk_reset_state("midjob_rst");
    for (int j = 0; j < 30; j++) begin
      set_in(0, 8'h00, 0, 32'h0, (j == 10));
      #1;
      chk("post_rst_enable", 64'(o_wtb_enable), 64'd0);
      chk("post_rst_busy", 64'(o_busy), 64'd0);
      chk("post_rst_timeout", 64'(o_timeout), 64'd0);
      step();
    end
    set_in(1, 8'h07, 0, 32'h0, 0);
    #1;
    chk("new_push_err_ready", 64'(o_err_ready), 64'd1);
    step();
    set_in(0, 8'h00, 0, 32'h0, 0);
    #1;
    chk("new_push_level", 64'(o_level), 64'd1);
    chk("new_push_enable_early", 64'(o_wtb_enable), 64'd0);
    step();
    #1;
    chk("new_job_enable", 64'(o_wtb_enable), 64'd1);
    chk("new_job_mode", 64'(o_wtb_mode_select), 64'd0);
    chk("new_job_byte", 64'(o_wtb_byte), 64'h07);
    chk("new_job_level", 64'(o_level), 64'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
